// File: rtl/fir_frame_checker.sv
`default_nettype none
// ============================================================================
// Module   : fir_frame_checker
// Purpose  : Capture-and-compare sink for the FIR chain output. Discards a
//            programmable number of leading valid samples (pipeline fill),
//            captures a frame into an internal buffer, compares every
//            captured sample against a preloaded golden frame and reports
//            the mismatch count and first failing index. The captured frame
//            can be read back through a registered read port.
// Ports    : clk, rst_p (sync, active-high)
//            start, skip_cnt, frame_len      - frame arming
//            y_valid, y_in                   - filter output stream
//            exp_we, exp_addr, exp_data      - golden-frame write port
//            rd_addr, rd_data                - capture-buffer readback
//            busy, done, mismatch_cnt,
//            first_err_idx, first_err_valid  - status / results
// Revision : 1.0 - initial release
// ============================================================================
module fir_frame_checker #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int SKIP_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_p,
    input  logic                     start,
    input  logic [SKIP_W-1:0]        skip_cnt,
    input  logic [ADDR_W:0]          frame_len,
    input  logic                     y_valid,
    input  logic signed [DATA_W-1:0] y_in,
    input  logic                     exp_we,
    input  logic [ADDR_W-1:0]        exp_addr,
    input  logic signed [DATA_W-1:0] exp_data,
    input  logic [ADDR_W-1:0]        rd_addr,
    output logic signed [DATA_W-1:0] rd_data,
    output logic                     busy,
    output logic                     done,
    output logic [ADDR_W:0]          mismatch_cnt,
    output logic [ADDR_W-1:0]        first_err_idx,
    output logic                     first_err_valid
);

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_skip    = 2'd1;
    localparam logic [1:0] c_st_capture = 2'd2;
    localparam logic [1:0] c_st_done    = 2'd3;

    localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(DEPTH);

    logic [1:0]               r_state;
    logic [SKIP_W-1:0]        r_skip;
    logic [ADDR_W-1:0]        r_last;
    logic [ADDR_W-1:0]        r_idx;
    logic [ADDR_W:0]          r_mis;
    logic [ADDR_W-1:0]        r_fidx;
    logic                     r_fvalid;
    logic signed [DATA_W-1:0] r_rd_data;

    logic signed [DATA_W-1:0] r_cap [DEPTH];
    logic signed [DATA_W-1:0] r_exp [DEPTH];

    logic                     w_busy;
    logic [ADDR_W:0]          w_len;
    logic [ADDR_W-1:0]        w_last;
    logic                     w_cap_we;
    logic                     w_exp_we;
    logic                     w_mismatch;

    assign w_busy = (r_state == c_st_skip) || (r_state == c_st_capture);

    // A zero or oversized length means "whole buffer".
    assign w_len  = ((frame_len == '0) || (frame_len > c_depth)) ? c_depth : frame_len;
    assign w_last = ADDR_W'(w_len - 1'b1);

    // Reset takes priority over a capture write on the same edge so an
    // abandoned frame does not touch the buffer on its way out.
    assign w_cap_we   = (r_state == c_st_capture) && y_valid && !rst_p;
    // Golden frame is frozen while a frame is in progress.
    assign w_exp_we   = exp_we && !w_busy;
    assign w_mismatch = (y_in != r_exp[r_idx]);

    // Buffers are plain storage: never cleared by reset.
    always_ff @(posedge clk) begin
        if (w_cap_we) begin
            r_cap[r_idx] <= y_in;
        end
        if (w_exp_we) begin
            r_exp[exp_addr] <= exp_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_p) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_cap[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst_p) begin
            r_state  <= c_st_idle;
            r_skip   <= '0;
            r_last   <= '0;
            r_idx    <= '0;
            r_mis    <= '0;
            r_fidx   <= '0;
            r_fvalid <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle, c_st_done: begin
                    if (start) begin
                        r_skip   <= skip_cnt;
                        r_last   <= w_last;
                        r_idx    <= '0;
                        r_mis    <= '0;
                        r_fidx   <= '0;
                        r_fvalid <= 1'b0;
                        r_state  <= (skip_cnt != '0) ? c_st_skip : c_st_capture;
                    end
                end
                c_st_skip: begin
                    if (y_valid) begin
                        r_skip <= r_skip - 1'b1;
                        // The sample that exhausts the count is itself discarded.
                        if (r_skip == SKIP_W'(1)) begin
                            r_state <= c_st_capture;
                        end
                    end
                end
                c_st_capture: begin
                    if (y_valid) begin
                        if (w_mismatch) begin
                            r_mis <= r_mis + 1'b1;
                            if (!r_fvalid) begin
                                r_fidx   <= r_idx;
                                r_fvalid <= 1'b1;
                            end
                        end
                        r_idx <= r_idx + 1'b1;
                        if (r_idx == r_last) begin
                            r_state <= c_st_done;
                        end
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign rd_data         = r_rd_data;
    assign busy            = w_busy;
    assign done            = (r_state == c_st_done);
    assign mismatch_cnt    = r_mis;
    assign first_err_idx   = r_fidx;
    assign first_err_valid = r_fvalid;

endmodule
`default_nettype wire

// File: tb/tb_fir_frame_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_frame_checker
// Purpose  : Self-checking bench for fir_frame_checker. A frame-level model
//            derives captured data, mismatch count and first error index from
//            the stimulus and the golden frame.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_frame_checker;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int SKIP_W = 8;

    logic                     clk = 1'b0;
    logic                     rst_p;
    logic                     start;
    logic [SKIP_W-1:0]        skip_cnt;
    logic [ADDR_W:0]          frame_len;
    logic                     y_valid;
    logic signed [DATA_W-1:0] y_in;
    logic                     exp_we;
    logic [ADDR_W-1:0]        exp_addr;
    logic signed [DATA_W-1:0] exp_data;
    logic [ADDR_W-1:0]        rd_addr;
    logic signed [DATA_W-1:0] rd_data;
    logic                     busy;
    logic                     done;
    logic [ADDR_W:0]          mismatch_cnt;
    logic [ADDR_W-1:0]        first_err_idx;
    logic                     first_err_valid;

    always #5 clk = ~clk;

    fir_frame_checker #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .SKIP_W(SKIP_W)
    ) u_dut (
        .clk            (clk),
        .rst_p          (rst_p),
        .start          (start),
        .skip_cnt       (skip_cnt),
        .frame_len      (frame_len),
        .y_valid        (y_valid),
        .y_in           (y_in),
        .exp_we         (exp_we),
        .exp_addr       (exp_addr),
        .exp_data       (exp_data),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .busy           (busy),
        .done           (done),
        .mismatch_cnt   (mismatch_cnt),
        .first_err_idx  (first_err_idx),
        .first_err_valid(first_err_valid)
    );

    int checks = 0;
    int errors = 0;

    logic signed [DATA_W-1:0] exp_m [DEPTH];
    logic signed [DATA_W-1:0] cap_m [DEPTH];
    logic signed [DATA_W-1:0] stim [$];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_exp();
        for (int i = 0; i < DEPTH; i++) begin
            exp_we   = 1'b1;
            exp_addr = ADDR_W'(i);
            exp_data = exp_m[i];
            tick();
        end
        exp_we = 1'b0;
    endtask

    // Junk for the skipped part, then the golden frame with selected indices corrupted.
    task automatic make_stim(input int skip, input int len, input int cmask, input bit use_neg1);
        logic signed [DATA_W-1:0] v;
        stim.delete();
        for (int i = 0; i < skip; i++) stim.push_back($urandom);
        for (int i = 0; i < len; i++) begin
            v = exp_m[i];
            if (cmask[i]) v = use_neg1 ? -32'sd1 : (v ^ (32'sd1 <<< $urandom_range(0, 31)));
            stim.push_back(v);
        end
    endtask

    // mode: 0 back-to-back, 1 one idle cycle before each sample, 2 random gaps.
    task automatic run_frame(input string name, input int skip, input int flen, input int mode,
                             input int inject_at, input int want_edges, input bit readback);
        int len;
        int edges;
        int gaps;
        int mis;
        int fe;
        bit early;
        len = (flen == 0 || flen > DEPTH) ? DEPTH : flen;
        start     = 1'b1;
        skip_cnt  = SKIP_W'(skip);
        frame_len = (ADDR_W+1)'(flen);
        tick();
        start = 1'b0;
        edges = 1;
        early = 1'b0;
        check_val({name, "_busy_after_start"}, 64'(busy), 64'(1));
        check_val({name, "_done_after_start"}, 64'(done), 64'(0));
        for (int n = 0; n < stim.size(); n++) begin
            gaps = (mode == 0) ? 0 : (mode == 1) ? 1 : int'($urandom_range(0, 2));
            for (int g = 0; g < gaps; g++) begin
                y_valid = 1'b0;
                y_in    = $urandom;
                tick();
                edges++;
                if (done) early = 1'b1;
            end
            y_valid = 1'b1;
            y_in    = stim[n];
            if (n == inject_at) begin
                start     = 1'b1;
                skip_cnt  = SKIP_W'(5);
                frame_len = (ADDR_W+1)'(3);
                exp_we    = 1'b1;
                exp_addr  = ADDR_W'(len - 1);
                exp_data  = ~exp_m[len-1];
            end
            tick();
            edges++;
            start  = 1'b0;
            exp_we = 1'b0;
            if (n != stim.size() - 1 && done) early = 1'b1;
        end
        y_valid = 1'b0;
        check_val({name, "_done_early"}, 64'(early), 64'(0));
        check_val({name, "_done"}, 64'(done), 64'(1));
        check_val({name, "_busy_end"}, 64'(busy), 64'(0));
        if (want_edges > 0) check_val({name, "_latency"}, 64'(edges), 64'(want_edges));

        mis = 0;
        fe  = -1;
        for (int i = 0; i < len; i++) begin
            cap_m[i] = stim[skip+i];
            if (stim[skip+i] != exp_m[i]) begin
                mis++;
                if (fe < 0) fe = i;
            end
        end
        check_val({name, "_mismatch_cnt"}, 64'(mismatch_cnt), 64'(mis));
        check_val({name, "_first_err_valid"}, 64'(first_err_valid), 64'(fe >= 0));
        check_val({name, "_first_err_idx"}, 64'(first_err_idx), 64'((fe >= 0) ? fe : 0));
        if (readback) begin
            for (int i = 0; i < len; i++) begin
                rd_addr = ADDR_W'(i);
                tick();
                check_val($sformatf("%s_rd%0d", name, i), 64'(rd_data), 64'(cap_m[i]));
            end
        end
    endtask

    initial begin
        rst_p = 1'b1; start = 1'b0; skip_cnt = '0; frame_len = '0;
        y_valid = 1'b0; y_in = '0; exp_we = 1'b0; exp_addr = '0; exp_data = '0; rd_addr = '0;
        tick();
        tick();
        check_val("rst_busy", 64'(busy), 64'(0));
        check_val("rst_done", 64'(done), 64'(0));
        check_val("rst_mis", 64'(mismatch_cnt), 64'(0));
        check_val("rst_fev", 64'(first_err_valid), 64'(0));
        check_val("rst_fidx", 64'(first_err_idx), 64'(0));
        check_val("rst_rd", 64'(rd_data), 64'(0));
        rst_p = 1'b0;
        tick();

        // Clean frame, skip 3, length 10, back-to-back.
        for (int i = 0; i < DEPTH; i++) exp_m[i] = 32'(100 * i);
        load_exp();
        make_stim(3, 10, 0, 1'b0);
        run_frame("clean", 3, 10, 0, -1, 14, 1'b0);

        // Corrupted at idx 4 and 7 with -1, then read back idx 7.
        make_stim(3, 10, (1 << 4) | (1 << 7), 1'b1);
        run_frame("corrupt", 3, 10, 0, -1, 14, 1'b0);
        rd_addr = 4'd7;
        tick();
        check_val("corrupt_rd7", 64'(rd_data), 64'(-64'sd1));

        // Length 0 means full buffer, valid every other cycle.
        make_stim(0, DEPTH, 16'h0101, 1'b0);
        run_frame("full_alt", 0, 0, 1, -1, 33, 1'b1);

        // start and exp_we pulsed mid-capture must be ignored.
        make_stim(2, 8, 0, 1'b0);
        run_frame("inject", 2, 8, 0, 4, 11, 1'b0);
        make_stim(0, 8, 0, 1'b0);
        run_frame("exp_kept", 0, 8, 2, -1, 0, 1'b0);

        // Reset in the middle of capture (at idx 5) with errors already counted.
        start = 1'b1; skip_cnt = '0; frame_len = (ADDR_W+1)'(10);
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            y_valid = 1'b1;
            y_in    = (i >= 1 && i <= 3) ? -32'sd7 : exp_m[i];
            tick();
        end
        check_val("pre_rst_mis", 64'(mismatch_cnt), 64'(3));
        y_in  = exp_m[5];
        rst_p = 1'b1;
        tick();
        rst_p   = 1'b0;
        y_valid = 1'b0;
        check_val("midrst_busy", 64'(busy), 64'(0));
        check_val("midrst_done", 64'(done), 64'(0));
        check_val("midrst_mis", 64'(mismatch_cnt), 64'(0));
        check_val("midrst_fev", 64'(first_err_valid), 64'(0));
        make_stim(1, DEPTH, 16'h0020, 1'b0);
        run_frame("after_rst", 1, 0, 2, -1, 0, 1'b1);

        // Signed extremes: matches and sign-only / full inversions.
        exp_m[0] = 32'sh7FFFFFFF; exp_m[1] = 32'sh80000000;
        exp_m[2] = 32'sh7FFFFFFF; exp_m[3] = 32'sh80000000;
        exp_m[4] = 32'sh00000000; exp_m[5] = 32'shFFFFFFFF;
        exp_m[6] = 32'shFFFFFFFF;
        load_exp();
        stim.delete();
        stim.push_back(32'sh7FFFFFFF); stim.push_back(32'sh80000000);
        stim.push_back(32'sh80000000); stim.push_back(32'sh7FFFFFFF);
        stim.push_back(32'sh80000000); stim.push_back(32'sh7FFFFFFF);
        stim.push_back(32'shFFFFFFFF);
        run_frame("extremes", 0, 7, 0, -1, 8, 1'b1);

        // Randomized frames.
        for (int r = 0; r < 4; r++) begin
            int sk;
            int fl;
            int ln;
            for (int i = 0; i < DEPTH; i++) exp_m[i] = $urandom;
            load_exp();
            sk = $urandom_range(0, 5);
            fl = $urandom_range(0, 20);
            ln = (fl == 0 || fl > DEPTH) ? DEPTH : fl;
            make_stim(sk, ln, int'($urandom_range(0, 65535)) & int'($urandom_range(0, 65535)), 1'b0);
            run_frame($sformatf("rand%0d", r), sk, fl, 2, -1, 0, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
